// File: rtl/arb_mux_reg.sv
// N-input registered handshaked multiplexer: explicit select (MODE=0) or
// round-robin arbitration (MODE=1) feeding a one-entry valid/ready output register.
module arb_mux_reg #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN),
  parameter int unsigned MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_src
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] src_q, src_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0] eff_sel;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [SEL_W:0]   cand;
  logic             can_load;
  logic             xfer;

  assign can_load = !valid_q || out_ready;

  always_comb begin
    if (32'(sel) < NUM_IN) eff_sel = sel;
    else                   eff_sel = SEL_W'(NUM_IN - 1);
  end

  // Round-robin search walks rr_ptr, rr_ptr+1, ... with a wrap at NUM_IN;
  // cand is one bit wider so the unwrapped sum never overflows.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = '0;
    if (MODE == 0) begin
      gnt_idx   = eff_sel;
      gnt_found = in_valid[eff_sel];
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        cand = {1'b0, rr_ptr_q} + (SEL_W+1)'(k);
        if (cand >= (SEL_W+1)'(NUM_IN)) cand = cand - (SEL_W+1)'(NUM_IN);
        if (!gnt_found && in_valid[cand[SEL_W-1:0]]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready          = '0;
    in_ready[gnt_idx] = gnt_found && can_load && !rst;
  end

  assign xfer = gnt_found && can_load;

  always_comb begin
    data_d   = data_q;
    valid_d  = valid_q;
    src_d    = src_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      src_d   = gnt_idx;
      valid_d = 1'b1;
      if (MODE != 0) begin
        rr_ptr_d = (32'(gnt_idx) == NUM_IN - 1) ? '0 : gnt_idx + 1'b1;
      end
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      src_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      data_q   <= data_d;
      valid_q  <= valid_d;
      src_q    <= src_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_src   = src_q;

endmodule
